// File: rtl/ll_tx_framer.sv
// rtl/ll_tx_framer.sv - LocalLink TX framer: packs button state into fixed-length checksummed frames
// Frames are sent on button change or heartbeat timeout while the Aurora channel is up.
module ll_tx_framer #(
    parameter int          FRAME_WORDS      = 4,
    parameter logic [15:0] HEARTBEAT_CYCLES = 16'd50000
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        channel_up,
    input  logic [4:0]  buttons,
    input  logic        tx_dst_rdy_n,
    output logic [15:0] tx_d,
    output logic        tx_rem,
    output logic        tx_src_rdy_n,
    output logic        tx_sof_n,
    output logic        tx_eof_n,
    output logic        busy,
    output logic [7:0]  seq
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [7:0]  LAST_K  = 8'(FRAME_WORDS - 1);
    localparam logic [15:0] HB_LAST = HEARTBEAT_CYCLES - 16'd1;

    state_t      state_q, state_d;
    logic [7:0]  k_q, k_d;
    logic [7:0]  seq_q, seq_d;
    logic [4:0]  btn_q;
    logic [4:0]  btn_sent_q, btn_sent_d;
    logic [4:0]  snap_q, snap_d;
    logic [15:0] hb_cnt_q, hb_cnt_d;
    logic [15:0] csum_q, csum_d;
    logic [15:0] word;

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q    <= IDLE;
            k_q        <= 8'd0;
            seq_q      <= 8'd0;
            btn_q      <= 5'd0;
            btn_sent_q <= 5'd0;
            snap_q     <= 5'd0;
            hb_cnt_q   <= 16'd0;
            csum_q     <= 16'd0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            seq_q      <= seq_d;
            btn_q      <= buttons;
            btn_sent_q <= btn_sent_d;
            snap_q     <= snap_d;
            hb_cnt_q   <= hb_cnt_d;
            csum_q     <= csum_d;
        end
    end

    // Running XOR of accepted words becomes the final (checksum) word.
    always_comb begin
        if (k_q == 8'd0)
            word = {8'hA5, seq_q};
        else if (k_q == 8'd1)
            word = {11'b0, snap_q};
        else if (k_q == LAST_K)
            word = csum_q;
        else
            word = {8'hF0, k_q};
    end

    always_comb begin
        tx_d         = 16'd0;
        tx_rem       = 1'b0;
        tx_src_rdy_n = 1'b1;
        tx_sof_n     = 1'b1;
        tx_eof_n     = 1'b1;
        busy         = 1'b0;
        seq          = seq_q;
        if (state_q == SEND) begin
            tx_d         = word;
            tx_src_rdy_n = 1'b0;
            tx_sof_n     = (k_q != 8'd0);
            tx_eof_n     = (k_q != LAST_K);
            tx_rem       = (k_q == LAST_K);
            busy         = 1'b1;
        end
    end

    // Snapshot lives in snap_q until the frame completes, so an abort leaves btn_sent untouched
    // and the pending change is naturally resent.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        seq_d      = seq_q;
        btn_sent_d = btn_sent_q;
        snap_d     = snap_q;
        hb_cnt_d   = hb_cnt_q;
        csum_d     = csum_q;
        case (state_q)
            IDLE: begin
                if (channel_up && ((btn_q != btn_sent_q) || (hb_cnt_q == HB_LAST))) begin
                    snap_d   = btn_q;
                    k_d      = 8'd0;
                    csum_d   = 16'd0;
                    hb_cnt_d = 16'd0;
                    state_d  = SEND;
                end else if (channel_up) begin
                    hb_cnt_d = hb_cnt_q + 16'd1;
                end else begin
                    hb_cnt_d = 16'd0;
                end
            end
            SEND: begin
                if (!channel_up) begin
                    state_d = IDLE;
                end else if (!tx_dst_rdy_n) begin
                    csum_d = csum_q ^ word;
                    if (k_q == LAST_K) begin
                        seq_d      = seq_q + 8'd1;
                        btn_sent_d = snap_q;
                        hb_cnt_d   = 16'd0;
                        state_d    = IDLE;
                    end else begin
                        k_d = k_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ll_tx_framer.sv
// tb/tb_ll_tx_framer.sv - self-checking bench for ll_tx_framer
// Frame-level reference model plus directed scenarios with literal frame contents.
module tb_ll_tx_framer;

    localparam int FW = 4;
    localparam int HB = 16;

    logic        clk = 1'b0;
    logic        RESET;
    logic        channel_up;
    logic [4:0]  buttons;
    logic        tx_dst_rdy_n;
    logic [15:0] tx_d;
    logic        tx_rem, tx_src_rdy_n, tx_sof_n, tx_eof_n, busy;
    logic [7:0]  seq;

    always #5 clk = ~clk;

    ll_tx_framer #(.FRAME_WORDS(FW), .HEARTBEAT_CYCLES(16'd16)) dut (
        .clk(clk), .RESET(RESET), .channel_up(channel_up), .buttons(buttons),
        .tx_dst_rdy_n(tx_dst_rdy_n), .tx_d(tx_d), .tx_rem(tx_rem),
        .tx_src_rdy_n(tx_src_rdy_n), .tx_sof_n(tx_sof_n), .tx_eof_n(tx_eof_n),
        .busy(busy), .seq(seq)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    logic [15:0] log_d[$];
    int          log_cyc[$];
    bit          log_sof[$];
    bit          log_eof[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] base_word(input int k, input logic [7:0] s, input logic [4:0] b);
        if (k == 0) return {8'hA5, s};
        if (k == 1) return {11'b0, b};
        return {8'hF0, 8'(k)};
    endfunction

    function automatic logic [15:0] frame_word(input int k, input logic [7:0] s, input logic [4:0] b);
        logic [15:0] x;
        if (k < FW - 1) return base_word(k, s, b);
        x = 16'd0;
        for (int j = 0; j < FW - 1; j++) x = x ^ base_word(j, s, b);
        return x;
    endfunction

    // Reference model: frame-level view of the link.
    bit         m_sending;
    int         m_idx;
    logic [7:0] m_seq;
    logic [4:0] m_btnq, m_sent, m_snap;
    int         m_hb;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (RESET) begin
            m_sending <= 1'b0; m_idx <= 0; m_seq <= 8'd0;
            m_btnq <= 5'd0; m_sent <= 5'd0; m_snap <= 5'd0; m_hb <= 0;
        end else begin
            m_btnq <= buttons;
            if (m_sending) begin
                if (!channel_up) begin
                    m_sending <= 1'b0;
                end else if (!tx_dst_rdy_n) begin
                    if (m_idx == FW - 1) begin
                        m_sending <= 1'b0;
                        m_seq     <= m_seq + 8'd1;
                        m_sent    <= m_snap;
                        m_hb      <= 0;
                    end else begin
                        m_idx <= m_idx + 1;
                    end
                end
            end else if (channel_up && (m_btnq != m_sent || m_hb == HB - 1)) begin
                m_snap    <= m_btnq;
                m_sending <= 1'b1;
                m_idx     <= 0;
                m_hb      <= 0;
            end else begin
                m_hb <= channel_up ? m_hb + 1 : 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("src_rdy_n", tx_src_rdy_n, !m_sending);
            check("busy", busy, m_sending);
            check("seq", seq, m_seq);
            if (m_sending) begin
                check("tx_d", tx_d, frame_word(m_idx, m_seq, m_snap));
                check("sof_n", tx_sof_n, m_idx != 0);
                check("eof_n", tx_eof_n, m_idx != FW - 1);
                check("rem", tx_rem, m_idx == FW - 1);
            end
            if (!tx_src_rdy_n && !tx_dst_rdy_n && channel_up) begin
                log_d.push_back(tx_d);
                log_cyc.push_back(cyc);
                log_sof.push_back(!tx_sof_n);
                log_eof.push_back(!tx_eof_n);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input logic val, input string name);
        int n = 0;
        while (busy !== val && n < 60) begin
            step();
            n++;
        end
        check(name, busy, val);
    endtask

    task automatic wait_frame(input string name);
        wait_busy(1'b1, {name, "_start"});
        wait_busy(1'b0, {name, "_end"});
    endtask

    task automatic check_frame(input string name, input int base, input bit consec,
                               input logic [15:0] w0, input logic [15:0] w1,
                               input logic [15:0] w2, input logic [15:0] w3);
        logic [15:0] w[4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        total++;
        if (log_d.size() < base + 4) begin
            bad++;
            $display("FAIL %s_count: got %0d transfers expected %0d", name, log_d.size() - base, 4);
            return;
        end
        for (int i = 0; i < 4; i++) begin
            check({name, "_word"}, log_d[base + i], w[i]);
            check({name, "_sof"}, log_sof[base + i], i == 0);
            check({name, "_eof"}, log_eof[base + i], i == 3);
            if (consec) check({name, "_gap"}, log_cyc[base + i] - log_cyc[base], i);
        end
    endtask

    initial begin
        int base, c0;
        int n;
        RESET = 1'b1; channel_up = 1'b0; buttons = 5'd0; tx_dst_rdy_n = 1'b1;
        repeat (3) step();
        check("rst_tx_d", tx_d, 16'h0000);
        check("rst_src_rdy_n", tx_src_rdy_n, 1'b1);
        check("rst_sof_n", tx_sof_n, 1'b1);
        check("rst_eof_n", tx_eof_n, 1'b1);
        check("rst_rem", tx_rem, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_seq", seq, 8'd0);
        chk_en = 1'b1;
        RESET = 1'b0;

        // 1: channel down, buttons toggling
        for (int i = 0; i < 50; i++) begin
            buttons = 5'(i);
            step();
        end
        check("down_no_xfer", log_d.size(), 0);
        check("down_src_rdy_n", tx_src_rdy_n, 1'b1);
        check("down_seq", seq, 8'd0);
        buttons = 5'd0;
        step(); step();

        // 2: first frame on change
        base = log_d.size();
        channel_up = 1'b1; tx_dst_rdy_n = 1'b0; buttons = 5'b00101;
        c0 = cyc;
        wait_frame("f1");
        check_frame("f1", base, 1'b1, 16'hA500, 16'h0005, 16'hF002, 16'h5507);
        if (log_d.size() > base) check("f1_latency", log_cyc[base] - c0, 2);
        check("f1_seq", seq, 8'd1);

        // 4: heartbeat frame
        base = log_d.size();
        wait_frame("hb");
        check_frame("hb", base, 1'b1, 16'hA501, 16'h0005, 16'hF002, 16'h5506);
        if (log_d.size() > base && base > 0) check("hb_delay", log_cyc[base] - log_cyc[base - 1], 17);
        check("hb_seq", seq, 8'd2);

        // 3: stall on word 1
        base = log_d.size();
        buttons = 5'b00011;
        n = 0;
        while (tx_sof_n !== 1'b0 && n < 40) begin step(); n++; end
        check("stall_sof_seen", tx_sof_n, 1'b0);
        step();
        tx_dst_rdy_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold_d", tx_d, 16'h0003);
            check("stall_hold_src", tx_src_rdy_n, 1'b0);
        end
        tx_dst_rdy_n = 1'b0;
        wait_busy(1'b0, "stall_end");
        check_frame("stall", base, 1'b0, 16'hA502, 16'h0003, 16'hF002, 16'h5503);
        check("stall_xfers", log_d.size() - base, 4);
        check("stall_seq", seq, 8'd3);

        // 5: abort after word 1, then resend with current buttons
        base = log_d.size();
        buttons = 5'b01000;
        n = 0;
        while (!(tx_src_rdy_n === 1'b0 && tx_d === 16'h0008) && n < 40) begin step(); n++; end
        check("abort_w1_seen", tx_d, 16'h0008);
        step();
        channel_up = 1'b0; tx_dst_rdy_n = 1'b1;
        step();
        check("abort_src_rdy_n", tx_src_rdy_n, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_seq", seq, 8'd3);
        check("abort_xfers", log_d.size() - base, 2);
        buttons = 5'b01001;
        repeat (4) step();
        base = log_d.size();
        channel_up = 1'b1; tx_dst_rdy_n = 1'b0;
        wait_frame("resend");
        check_frame("resend", base, 1'b1, 16'hA503, 16'h0009, 16'hF002, 16'h5508);
        check("resend_seq", seq, 8'd4);

        // 6: change during frame -> back-to-back frame after one idle cycle
        base = log_d.size();
        buttons = 5'b00101;
        wait_busy(1'b1, "chg_start");
        step();
        buttons = 5'b10000;
        wait_busy(1'b0, "chg_end1");
        wait_frame("chg2");
        check_frame("chg1", base, 1'b1, 16'hA504, 16'h0005, 16'hF002, 16'h5503);
        check_frame("chg2", base + 4, 1'b1, 16'hA505, 16'h0010, 16'hF002, 16'h5517);
        if (log_d.size() >= base + 5) check("chg_gap", log_cyc[base + 4] - log_cyc[base + 3], 2);
        check("chg_seq", seq, 8'd6);

        // seq wrap 255 -> 0
        for (int i = 0; i < 250; i++) begin
            buttons = (i % 2 == 0) ? 5'b00001 : 5'b00010;
            wait_frame("wrap");
        end
        check("wrap_seq", seq, 8'd0);

        // reset mid-frame
        buttons = 5'b11111;
        wait_busy(1'b1, "rst_mid_start");
        step();
        RESET = 1'b1;
        step();
        check("rstmid_src_rdy_n", tx_src_rdy_n, 1'b1);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_seq", seq, 8'd0);
        check("rstmid_tx_d", tx_d, 16'h0000);
        check("rstmid_sof_n", tx_sof_n, 1'b1);
        RESET = 1'b0;
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
